// File: rtl/gfx256_wbm_arb_if.sv
// Requester-side and bus-master-side signal bundle for the gfx256 Wishbone master arbiter.
// slave = arbiter view, master = view of the requesters plus bus-master port.
interface gfx256_wbm_arb_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]     req_i;
   logic [NREQ-1:0]     we_i;
   logic [NREQ-1:0]     lock_i;
   logic [NREQ*32-1:0]  adr_i;
   logic [NREQ*32-1:0]  sel_i;
   logic [NREQ*256-1:0] dat_i;
   logic [NREQ-1:0]     ack_o;
   logic [255:0]        rdat_o;
   logic [NREQ-1:0]     grant_o;
   logic                busy_o;
   logic                m_read_request_o;
   logic                m_write_request_o;
   logic [31:0]         m_addr_o;
   logic [31:0]         m_sel_o;
   logic [255:0]        m_dat_o;
   logic [255:0]        m_dat_i;
   logic                m_ack_i;

   modport slave (
      input  req_i, we_i, lock_i, adr_i, sel_i, dat_i, m_dat_i, m_ack_i,
      output ack_o, rdat_o, grant_o, busy_o, m_read_request_o, m_write_request_o,
             m_addr_o, m_sel_o, m_dat_o
   );

   modport master (
      output req_i, we_i, lock_i, adr_i, sel_i, dat_i, m_dat_i, m_ack_i,
      input  ack_o, rdat_o, grant_o, busy_o, m_read_request_o, m_write_request_o,
             m_addr_o, m_sel_o, m_dat_o
   );
endinterface

// File: rtl/gfx256_wbm_arb.sv
// Round-robin arbiter with bounded grant locking in front of the gfx256 bus-master port.
// One transaction at a time; requests appear the cycle after grant, ack_o coincides with m_ack_i.
module gfx256_wbm_arb #(
   parameter int NREQ     = 4,
   parameter int MAX_LOCK = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   gfx256_wbm_arb_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAX_LOCK + 1);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] gnt_q, gnt_d;
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] own_q, own_d;
   logic          own_v_q, own_v_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic          we_q, we_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   sel_q, sel_d;
   logic [255:0]  dat_q, dat_d;

   logic [IW-1:0] pick;
   logic [IW-1:0] cand;
   logic          found;
   logic [CW-1:0] cnt_next;
   logic          issue;

   // Owner keeps the grant while locked; otherwise search upward from last+1, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = last_q;
      cand  = last_q;
      if (own_v_q && bus.req_i[own_q]) begin
         found = 1'b1;
         pick  = own_q;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!found && bus.req_i[cand]) begin
               found = 1'b1;
               pick  = cand;
            end
         end
      end
      cnt_next = (own_v_q && (own_q == pick)) ? lock_cnt_q + 1'b1 : CW'(1);
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      own_d      = own_q;
      own_v_d    = own_v_q;
      lock_cnt_d = lock_cnt_q;
      we_d       = we_q;
      adr_d      = adr_q;
      sel_d      = sel_q;
      dat_d      = dat_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = ISSUE;
               gnt_d   = pick;
               last_d  = pick;
               we_d    = bus.we_i[pick];
               adr_d   = bus.adr_i[int'(pick)*32 +: 32];
               sel_d   = bus.sel_i[int'(pick)*32 +: 32];
               dat_d   = bus.dat_i[int'(pick)*256 +: 256];
               // cnt_next counts this grant, so the owner gets at most MAX_LOCK in a row
               if (bus.lock_i[pick] && (cnt_next < CW'(MAX_LOCK))) begin
                  own_v_d    = 1'b1;
                  own_d      = pick;
                  lock_cnt_d = cnt_next;
               end else begin
                  own_v_d    = 1'b0;
                  lock_cnt_d = '0;
               end
            end
         end
         ISSUE: begin
            if (bus.m_ack_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         last_q     <= IW'(NREQ - 1);
         own_q      <= '0;
         own_v_q    <= 1'b0;
         lock_cnt_q <= '0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         sel_q      <= '0;
         dat_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         own_q      <= own_d;
         own_v_q    <= own_v_d;
         lock_cnt_q <= lock_cnt_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         sel_q      <= sel_d;
         dat_q      <= dat_d;
      end
   end

   assign issue = (state_q == ISSUE);

   // The port samples requests during its ack cycle, so the ack must mask them.
   assign bus.m_read_request_o  = issue & ~we_q & ~bus.m_ack_i;
   assign bus.m_write_request_o = issue &  we_q & ~bus.m_ack_i;
   assign bus.m_addr_o          = adr_q;
   assign bus.m_sel_o           = sel_q;
   assign bus.m_dat_o           = dat_q;
   assign bus.busy_o            = issue;
   assign bus.grant_o           = issue ? (NREQ'(1) << gnt_q) : '0;
   assign bus.ack_o             = (issue && bus.m_ack_i) ? (NREQ'(1) << gnt_q) : '0;
   assign bus.rdat_o            = (issue && bus.m_ack_i) ? bus.m_dat_i : '0;
endmodule

// File: tb/tb_gfx256_wbm_arb.sv
// Scoreboard bench for gfx256_wbm_arb: per-requester command drivers, a bus-master port model,
// and a monitor that pops the expected grant order on every ack_o.
module tb_gfx256_wbm_arb;
   localparam int NREQ = 4;

   typedef struct packed {
      logic        we;
      logic        lock;
      logic [31:0] adr;
   } cmd_t;

   typedef struct packed {
      logic [7:0]  who;
      logic        we;
      logic [31:0] adr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gfx256_wbm_arb_if #(.NREQ(NREQ)) bus ();

   gfx256_wbm_arb #(.NREQ(NREQ), .MAX_LOCK(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   int        tests  = 0;
   int        fails  = 0;
   int        ntrans = 0;
   int        lat    = 3;
   logic      spur   = 1'b0;
   cmd_t      cmds [NREQ][32];
   int        hd [NREQ] = '{default: 0};
   int        tl [NREQ] = '{default: 0};
   logic [NREQ-1:0] acked = '0;
   logic      seen_wr = 1'b0;
   logic      seen_rd = 1'b0;
   exp_t      exp_q [$];

   function automatic logic [255:0] mk_dat(input logic [31:0] a);
      return {8{a ^ 32'h5A5A_0000}};
   endfunction
   function automatic logic [31:0] mk_sel(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction
   function automatic logic [255:0] rd_dat(input logic [31:0] a);
      return {8{a ^ 32'hA5A5_A5A5}};
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic push(input int k, input logic we, input logic lock, input logic [31:0] adr);
      cmds[k][tl[k]] = '{we: we, lock: lock, adr: adr};
      tl[k]++;
   endtask

   task automatic expect_tx(input int k, input logic we, input logic [31:0] adr);
      exp_q.push_back('{who: 8'(k), we: we, adr: adr});
   endtask

   function automatic logic pending();
      logic p = (exp_q.size() != 0);
      for (int k = 0; k < NREQ; k++) if (hd[k] < tl[k]) p = 1'b1;
      return p;
   endfunction

   task automatic drop_all();
      for (int k = 0; k < NREQ; k++) tl[k] = hd[k];
      exp_q.delete();
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (pending() && n < 400) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 400) begin
         fails++;
         $display("FAIL %s_timeout: %0d expected acks still outstanding", nm, exp_q.size());
         drop_all();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic wait_grant(input int k, input string nm);
      int n = 0;
      while (bus.grant_o !== NREQ'(1 << k) && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 100) begin
         fails++;
         $display("FAIL %s_grant_timeout: grant %0h never reached %0h", nm, bus.grant_o, 1 << k);
      end
   endtask

   task automatic wait_busy(input string nm);
      int n = 0;
      while (bus.busy_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 100) begin
         fails++;
         $display("FAIL %s_busy_timeout: busy_o stayed %0b", nm, bus.busy_o);
      end
   endtask

   // Requester drivers: present the head command, advance past it on the edge after its ack.
   initial begin
      bus.req_i  = '0;
      bus.we_i   = '0;
      bus.lock_i = '0;
      bus.adr_i  = '0;
      bus.sel_i  = '0;
      bus.dat_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NREQ; k++) begin
            if (acked[k]) begin
               acked[k] = 1'b0;
               if (hd[k] < tl[k]) hd[k]++;
            end
            if (hd[k] < tl[k]) begin
               bus.req_i[k]            = 1'b1;
               bus.we_i[k]             = cmds[k][hd[k]].we;
               bus.lock_i[k]           = cmds[k][hd[k]].lock;
               bus.adr_i[k*32 +: 32]   = cmds[k][hd[k]].adr;
               bus.sel_i[k*32 +: 32]   = mk_sel(cmds[k][hd[k]].adr);
               bus.dat_i[k*256 +: 256] = mk_dat(cmds[k][hd[k]].adr);
            end else begin
               bus.req_i[k]  = 1'b0;
               bus.lock_i[k] = 1'b0;
            end
         end
      end
   end

   // Bus-master port model: acks after `lat` busy cycles with address-derived read data.
   initial begin
      int cnt = 0;
      bus.m_ack_i = 1'b0;
      bus.m_dat_i = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.m_ack_i = 1'b0;
         bus.m_dat_i = '0;
         if (rst || !bus.busy_o) begin
            cnt = 0;
         end else begin
            cnt++;
            if (cnt >= lat) begin
               bus.m_ack_i = 1'b1;
               bus.m_dat_i = rd_dat(bus.m_addr_o);
               cnt = 0;
               ntrans++;
            end
         end
         if (spur) bus.m_ack_i = 1'b1;
      end
   end

   // Monitor: checks every ack against the head of the expected-order queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.busy_o && !bus.m_ack_i) begin
            seen_wr = bus.m_write_request_o;
            seen_rd = bus.m_read_request_o;
         end
         if (!rst && bus.ack_o != '0) begin
            acked = acked | bus.ack_o;
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", 256'(bus.ack_o), 256'(0));
            end else begin
               e = exp_q.pop_front();
               chk("ack_onehot", 256'(bus.ack_o), 256'(1 << e.who));
               chk("grant_match", 256'(bus.grant_o), 256'(1 << e.who));
               chk("addr", 256'(bus.m_addr_o), 256'(e.adr));
               chk("sel", 256'(bus.m_sel_o), 256'(mk_sel(e.adr)));
               chk("req_gated", 256'({bus.m_read_request_o, bus.m_write_request_o}), 256'(0));
               chk("req_kind", 256'({seen_wr, seen_rd}), 256'({e.we, ~e.we}));
               if (e.we) chk("wdat", bus.m_dat_o, mk_dat(e.adr));
               else      chk("rdat", bus.rdat_o, rd_dat(e.adr));
            end
         end
      end
   end

   initial begin
      int n;
      int n0;

      // Reset state
      @(negedge clk);
      chk("rst_ack", 256'(bus.ack_o), 256'(0));
      chk("rst_rdat", bus.rdat_o, 256'(0));
      chk("rst_grant", 256'(bus.grant_o), 256'(0));
      chk("rst_busy", 256'(bus.busy_o), 256'(0));
      chk("rst_req", 256'({bus.m_read_request_o, bus.m_write_request_o}), 256'(0));
      chk("rst_addr", 256'(bus.m_addr_o), 256'(0));
      chk("rst_sel", 256'(bus.m_sel_o), 256'(0));
      chk("rst_wdat", bus.m_dat_o, 256'(0));
      @(negedge clk);
      rst = 1'b0;

      // Round robin: all four request together, requester 0 has a second command
      for (int k = 0; k < NREQ; k++) push(k, 1'b0, 1'b0, 32'h0000_1000 + 32'(k * 16));
      push(0, 1'b0, 1'b0, 32'h0000_2000);
      for (int k = 0; k < NREQ; k++) expect_tx(k, 1'b0, 32'h0000_1000 + 32'(k * 16));
      expect_tx(0, 1'b0, 32'h0000_2000);
      wait_drain("rr");

      // Single read with request latency
      n0 = ntrans;
      push(0, 1'b0, 1'b0, 32'h1000_0020);
      expect_tx(0, 1'b0, 32'h1000_0020);
      n = 0;
      while (!bus.req_i[0] && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("lat_idle_busy", 256'(bus.busy_o), 256'(0));
      @(negedge clk);
      chk("lat_rreq", 256'(bus.m_read_request_o), 256'(1));
      chk("lat_grant", 256'(bus.grant_o), 256'(1));
      wait_drain("single");
      chk("single_ntrans", 256'(ntrans - n0), 256'(1));

      // Locked read-modify-write by requester 2 while requester 1 waits
      push(2, 1'b0, 1'b1, 32'h0000_0040);
      push(2, 1'b1, 1'b0, 32'h0000_0040);
      expect_tx(2, 1'b0, 32'h0000_0040);
      expect_tx(2, 1'b1, 32'h0000_0040);
      expect_tx(1, 1'b0, 32'h0000_0100);
      wait_grant(2, "rmw");
      push(1, 1'b0, 1'b0, 32'h0000_0100);
      wait_drain("rmw");

      // Lock bound: requester 0 locked for six commands, requester 3 cuts in after four
      for (int i = 0; i < 6; i++) push(0, 1'(i % 2), 1'b1, 32'h0000_0200 + 32'(i * 4));
      for (int i = 0; i < 4; i++) expect_tx(0, 1'(i % 2), 32'h0000_0200 + 32'(i * 4));
      expect_tx(3, 1'b1, 32'h0000_0300);
      for (int i = 4; i < 6; i++) expect_tx(0, 1'(i % 2), 32'h0000_0200 + 32'(i * 4));
      wait_grant(0, "bound");
      push(3, 1'b1, 1'b0, 32'h0000_0300);
      wait_drain("bound");

      // Reset while a transaction is outstanding
      lat = 20;
      push(0, 1'b0, 1'b0, 32'h0000_0500);
      wait_busy("mid_rst");
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 256'(bus.busy_o), 256'(0));
      chk("midrst_grant", 256'(bus.grant_o), 256'(0));
      chk("midrst_req", 256'({bus.m_read_request_o, bus.m_write_request_o}), 256'(0));
      chk("midrst_addr", 256'(bus.m_addr_o), 256'(0));
      chk("midrst_ack", 256'(bus.ack_o), 256'(0));
      drop_all();
      acked = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      lat = 3;
      push(0, 1'b0, 1'b0, 32'h0000_0600);
      push(1, 1'b1, 1'b0, 32'h0000_0604);
      expect_tx(0, 1'b0, 32'h0000_0600);
      expect_tx(1, 1'b1, 32'h0000_0604);
      wait_drain("post_rst");

      // Address change during ISSUE must not reach the bus
      push(2, 1'b0, 1'b0, 32'h0000_0300);
      expect_tx(2, 1'b0, 32'h0000_0300);
      wait_busy("ignore");
      @(negedge clk);
      cmds[2][hd[2]].adr = 32'h0000_03FC;
      @(negedge clk);
      chk("ignore_addr_hold", 256'(bus.m_addr_o), 256'(32'h0000_0300));
      wait_drain("ignore");

      // Spurious ack while idle
      spur = 1'b1;
      @(negedge clk);
      chk("spur_ack", 256'(bus.ack_o), 256'(0));
      chk("spur_busy", 256'(bus.busy_o), 256'(0));
      spur = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("total_ntrans", 256'(ntrans), 256'(19));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
